cgp_exhaustive_eval: RTL and testbench

- Sequential fitness evaluator that sits directly upstream of an evolved combinational candidate (e.g. the 8-in/7-out dc2 benchmark netlist) and consumes its outputs.
- Sweeps all 2^N_IN input vectors into the candidate and into a golden copy of the benchmark, then compares the two output words.
- Accumulates the total Hamming distance, a per-output failure mask and a perfect-match flag, which the CGP loop uses as the candidate's fitness.

---
 rtl/cgp_exhaustive_eval.sv | 124 ++++++++++++
 tb/tb_cgp_exhaustive_eval.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/cgp_exhaustive_eval.sv
// Exhaustive fitness sweep: drives every input vector into a candidate and a golden netlist,
// accumulating mismatched output bits, a sticky per-output failure mask and a perfect flag.
module cgp_exhaustive_eval #(
    parameter int N_IN       = 8,
    parameter int N_OUT      = 7,
    parameter int SETTLE_CYC = 1,
    parameter int ERR_W      = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [N_IN-1:0]  vec_out,
    input  logic [N_OUT-1:0] cand_in,
    input  logic [N_OUT-1:0] gold_in,
    output logic             busy,
    output logic             done,
    output logic [ERR_W-1:0] err_count,
    output logic [N_OUT-1:0] out_fail,
    output logic             perfect
);

    // state  | meaning
    // IDLE   | waiting for start; results and last vector held
    // HOLD   | vector applied, waiting for candidate/golden outputs to settle
    // SAMPLE | compare outputs, accumulate, step to next vector
    // FIN    | one-cycle done pulse, results final
    typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, FIN} state_t;

    localparam logic [3:0] HOLD_LOAD = 4'(SETTLE_CYC);
    localparam state_t     VEC_FIRST = (SETTLE_CYC == 0) ? SAMPLE : HOLD;

    state_t           state, state_nxt;
    logic [3:0]       hold_cnt;
    logic [N_OUT-1:0] mis;
    logic [ERR_W-1:0] mis_pop;
    logic [ERR_W-1:0] err_sum;
    logic             last_vec;
    logic             accept, accumulate, hold_dec, cancel;

    assign mis      = cand_in ^ gold_in;
    assign last_vec = &vec_out;
    assign err_sum  = err_count + mis_pop;

    always_comb begin
        mis_pop = '0;
        for (int i = 0; i < N_OUT; i++) begin
            mis_pop = mis_pop + ERR_W'(mis[i]);
        end
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        accumulate = 1'b0;
        hold_dec   = 1'b0;
        cancel     = 1'b0;
        case (state)
            IDLE: begin
                // abort has priority over a simultaneous start
                if (start && !abort) begin
                    accept    = 1'b1;
                    state_nxt = VEC_FIRST;
                end
            end
            HOLD: begin
                if (abort) begin
                    cancel    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    hold_dec = 1'b1;
                    if (hold_cnt <= 4'd1) state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    cancel    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    accumulate = 1'b1;
                    state_nxt  = last_vec ? FIN : VEC_FIRST;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            vec_out   <= '0;
            hold_cnt  <= '0;
            err_count <= '0;
            out_fail  <= '0;
            perfect   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                vec_out   <= '0;
                hold_cnt  <= HOLD_LOAD;
                err_count <= '0;
                out_fail  <= '0;
                perfect   <= 1'b0;
            end
            if (hold_dec) hold_cnt <= hold_cnt - 4'd1;
            if (accumulate) begin
                err_count <= err_sum;
                out_fail  <= out_fail | mis;
                if (last_vec) begin
                    perfect <= (err_sum == '0);
                end else begin
                    vec_out  <= vec_out + 1'b1;
                    hold_cnt <= HOLD_LOAD;
                end
            end
            if (cancel) perfect <= 1'b0;
        end
    end

    assign busy = (state == HOLD) || (state == SAMPLE);
    assign done = (state == FIN);

endmodule

// File: tb/tb_cgp_exhaustive_eval.sv
// Bench for cgp_exhaustive_eval: behavioural candidate/golden netlists, scoreboard of expected
// sweep results, plus restart, abort, start/abort collision and mid-sweep reset scenarios.
module tb_cgp_exhaustive_eval;

    typedef struct {
        int err;
        int fail;
        int perf;
        int lat;
        int busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start0 = 1'b0, start1 = 1'b0, abort = 1'b0;
    logic [7:0] vec0, vec1;
    logic [6:0] cand0, gold0, cand1, gold1;
    logic       busy0, done0, perf0, busy1, done1, perf1;
    logic [10:0] err0, err1;
    logic [6:0] fail0, fail1;

    int  sel  = 0;
    int  mode = 0;
    int  checks = 0;
    int  errors = 0;
    exp_t sb[$];

    logic [7:0]  vec_m;
    logic        busy_m, done_m, perf_m;
    logic [10:0] err_m;
    logic [6:0]  fail_m;

    always #5 clk = ~clk;

    cgp_exhaustive_eval #(.N_IN(8), .N_OUT(7), .SETTLE_CYC(1), .ERR_W(11)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort), .vec_out(vec0),
        .cand_in(cand0), .gold_in(gold0), .busy(busy0), .done(done0),
        .err_count(err0), .out_fail(fail0), .perfect(perf0));

    cgp_exhaustive_eval #(.N_IN(8), .N_OUT(7), .SETTLE_CYC(0), .ERR_W(11)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .vec_out(vec1),
        .cand_in(cand1), .gold_in(gold1), .busy(busy1), .done(done1),
        .err_count(err1), .out_fail(fail1), .perfect(perf1));

    function automatic logic [6:0] gold_f(input logic [7:0] v);
        logic [7:0] t;
        t = (v * 8'd37 + 8'd11) ^ (v >> 3);
        return t[6:0];
    endfunction

    function automatic logic [6:0] cand_f(input logic [7:0] v, input int m);
        logic [6:0] g;
        g = gold_f(v);
        case (m)
            1:       return g ^ 7'h01;
            2:       return (v == 8'hFF) ? (g ^ 7'h40) : g;
            3:       return ~g;
            default: return g;
        endcase
    endfunction

    always_comb begin
        gold0 = gold_f(vec0);
        cand0 = cand_f(vec0, mode);
        gold1 = gold_f(vec1);
        cand1 = cand_f(vec1, mode);
    end

    always_comb begin
        vec_m  = (sel == 1) ? vec1  : vec0;
        busy_m = (sel == 1) ? busy1 : busy0;
        done_m = (sel == 1) ? done1 : done0;
        perf_m = (sel == 1) ? perf1 : perf0;
        err_m  = (sel == 1) ? err1  : err0;
        fail_m = (sel == 1) ? fail1 : fail0;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: accumulate mismatches over the first nvec vectors.
    function automatic exp_t model(input int m, input int s, input int nvec);
        exp_t e;
        logic [6:0] d;
        e.err = 0; e.fail = 0;
        for (int v = 0; v < nvec; v++) begin
            d = cand_f(8'(v), m) ^ gold_f(8'(v));
            e.err  += $countones(d);
            e.fail |= int'(d);
        end
        e.perf = (e.err == 0) ? 1 : 0;
        e.lat  = 256 * (s + 1) + 1;
        e.busy = 256 * (s + 1);
        return e;
    endfunction

    task automatic drive_start(input int s, input logic v);
        if (s == 1) start1 = v; else start0 = v;
    endtask

    task automatic run_sweep(input int s, input int m, input int restart_at,
                             input int abort_at, input int rst_at);
        exp_t e, p;
        int   settle, n, bc;
        bit   fin;
        sel = s; mode = m;
        settle = (s == 1) ? 0 : 1;
        if (abort_at == 0 && rst_at == 0) sb.push_back(model(m, settle, 256));
        @(negedge clk);
        drive_start(s, 1'b1);
        @(negedge clk);
        drive_start(s, 1'b0);
        n = 1; bc = 0; fin = 0;
        while (!fin && n <= 2000) begin
            if (n == 1) begin
                check_val("vec_first", int'(vec_m), 0);
                check_val("busy_first", int'(busy_m), 1);
            end
            if (busy_m) bc++;
            if (done_m) begin
                fin = 1;
                if (abort_at != 0 || rst_at != 0) begin
                    check_val("unexpected_done", 1, 0);
                end else if (sb.size() == 0) begin
                    check_val("sb_empty", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check_val("latency", n, e.lat);
                    check_val("busy_cycles", bc, e.busy);
                    check_val("err_count", int'(err_m), e.err);
                    check_val("out_fail", int'(fail_m), e.fail);
                    check_val("perfect", int'(perf_m), e.perf);
                    @(negedge clk);
                    check_val("vec_idle", int'(vec_m), 255);
                    check_val("err_hold", int'(err_m), e.err);
                    check_val("done_pulse", int'(done_m), 0);
                end
            end
            if (abort_at != 0 && n == abort_at + 1) begin
                p = model(m, settle, (abort_at - 1) / (settle + 1));
                check_val("abort_busy", int'(busy_m), 0);
                check_val("abort_err", int'(err_m), p.err);
                check_val("abort_fail", int'(fail_m), p.fail);
                check_val("abort_perfect", int'(perf_m), 0);
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (done_m) check_val("abort_done", 1, 0);
                end
                check_val("abort_frozen", int'(err_m), p.err);
                fin = 1;
            end
            if (!fin && rst_at != 0 && n == rst_at) begin
                rst_n = 1'b0;
                #1;
                check_val("rst_vec", int'(vec_m), 0);
                check_val("rst_busy", int'(busy_m), 0);
                check_val("rst_done", int'(done_m), 0);
                check_val("rst_err", int'(err_m), 0);
                check_val("rst_fail", int'(fail_m), 0);
                check_val("rst_perfect", int'(perf_m), 0);
                @(negedge clk);
                rst_n = 1'b1;
                fin = 1;
            end
            if (!fin) begin
                drive_start(s, (n == restart_at) ? 1'b1 : 1'b0);
                abort = (abort_at != 0 && n == abort_at);
                @(negedge clk);
                n++;
            end
        end
        drive_start(s, 1'b0);
        abort = 1'b0;
        if (!fin) check_val("timeout", 1, 0);
    endtask

    initial begin
        sel = 0;
        #12;
        check_val("reset_vec", int'(vec0), 0);
        check_val("reset_busy", int'(busy0), 0);
        check_val("reset_err", int'(err0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_sweep(0, 0, 0, 0, 0);
        run_sweep(0, 1, 0, 0, 0);
        run_sweep(0, 2, 0, 0, 0);
        run_sweep(1, 3, 0, 0, 0);
        run_sweep(0, 0, 100, 0, 0);
        run_sweep(0, 1, 0, 200, 0);

        // start and abort together in IDLE: abort wins
        sel = 0;
        @(negedge clk);
        start0 = 1'b1; abort = 1'b1;
        @(negedge clk);
        start0 = 1'b0; abort = 1'b0;
        check_val("collide_busy", int'(busy0), 0);
        check_val("collide_err", int'(err0), 99);

        run_sweep(0, 1, 0, 0, 300);
        run_sweep(0, 1, 0, 0, 0);

        check_val("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
